// File: rtl/masked_pattern_detector.sv
// masked_pattern_detector: pipelined multi-lane masked pattern compare
// with saturating hit counter, sticky per-lane hits and a run-lock FSM.
//
// Ports:
//   clk, rst_n    rising-edge clock, async active-low reset
//   in_valid      in_data valid this cycle
//   in_data       CHANNELS lanes of WIDTH bits, lane k at [k*WIDTH +: WIDTH]
//   cfg_load      load cfg_pattern / cfg_mask on this edge
//   cfg_pattern   new compare pattern
//   cfg_mask      new compare mask (1 = bit compared)
//   clr           sync clear of hit_count, match_sticky and run FSM
//   out_valid     match / match_any valid
//   match         per-lane match of the current output sample
//   match_any     OR of match
//   match_sticky  per-lane OR of all matches since reset / clr
//   hit_count     saturating count of valid samples with any lane matching
//   run_lock      RUN_LEN consecutive matching samples seen, held until clr
module masked_pattern_detector #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8,
    parameter int RUN_LEN  = 3,
    parameter logic [WIDTH-1:0] PAT_RST = WIDTH'(4'b0100),
    parameter logic [WIDTH-1:0] MSK_RST = WIDTH'(4'b1111)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      cfg_load,
    input  logic [WIDTH-1:0]          cfg_pattern,
    input  logic [WIDTH-1:0]          cfg_mask,
    input  logic                      clr,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       match,
    output logic                      match_any,
    output logic [CHANNELS-1:0]       match_sticky,
    output logic [CNT_W-1:0]          hit_count,
    output logic                      run_lock
);

    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0]  RUN_LAST = RC_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } state_t;

    logic [WIDTH-1:0]          pat_q;
    logic [WIDTH-1:0]          msk_q;
    logic [CHANNELS*WIDTH-1:0] s0_data;
    logic                      s0_valid;
    logic [CHANNELS-1:0]       lane_hit;
    logic [CHANNELS-1:0]       match_d;
    logic                      hit_d;
    logic                      clr_q;
    logic                      fsm_step;
    state_t                    state_q;
    state_t                    state_d;
    logic [RC_W-1:0]           run_cnt_q;
    logic [RC_W-1:0]           run_cnt_d;
    logic                      run_lock_d;

    // Configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= PAT_RST;
            msk_q <= MSK_RST;
        end else if (cfg_load) begin
            pat_q <= cfg_pattern;
            msk_q <= cfg_mask;
        end
    end

    // Stage 0: data regs only load on valid so idle lanes stay quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_data <= '0;
        end else if (in_valid) begin
            s0_data <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= in_valid;
        end
    end

    // Stage 1 compare
    always_comb begin
        lane_hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            lane_hit[k] =
                ((s0_data[k*WIDTH +: WIDTH] ^ pat_q) & msk_q) == '0;
        end
        match_d = s0_valid ? lane_hit : '0;
        hit_d   = |match_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            match     <= '0;
            clr_q     <= 1'b0;
        end else begin
            out_valid <= s0_valid;
            match     <= match_d;
            clr_q     <= clr;
        end
    end

    assign match_any = |match;

    // Count / sticky see the sample as it is registered, so a clr on
    // the same edge drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (clr) begin
            hit_count <= '0;
        end else if (hit_d && hit_count != CNT_MAX) begin
            hit_count <= hit_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_sticky <= '0;
        end else if (clr) begin
            match_sticky <= '0;
        end else begin
            match_sticky <= match_sticky | match_d;
        end
    end

    // Run FSM works on the registered outputs; a sample registered
    // under clr is skipped on the following edge.
    assign fsm_step = out_valid & ~clr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        if (clr) begin
            state_d   = IDLE;
            run_cnt_d = '0;
        end else if (fsm_step) begin
            unique case (1'b1)
                (state_q == IDLE): begin
                    if (match_any) begin
                        run_cnt_d = RC_W'(1);
                        state_d   = (RUN_LEN == 1) ? LOCK : RUN;
                    end
                end
                (state_q == RUN): begin
                    if (!match_any) begin
                        state_d   = IDLE;
                        run_cnt_d = '0;
                    end else if (run_cnt_q == RUN_LAST) begin
                        state_d   = LOCK;
                    end else begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end
                (state_q == LOCK): begin
                    state_d = LOCK;
                end
                default: begin
                    state_d   = IDLE;
                    run_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        run_lock_d = (state_d == LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_lock <= 1'b0;
        end else begin
            run_lock <= run_lock_d;
        end
    end

endmodule
